// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Optional ack timeout is enabled with the DMEM_TIMEOUT_EN macro.
package dmem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  localparam int STARVE_LIMIT_DEF   = 8;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY_CORE = 2'd1,
    BUSY_DMA  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
  } dm_req_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of cycles the DMA master has waited without a grant.
// Clears when the request is withdrawn or granted.
module dmem_arb_starve_ctr #(
  parameter int LIMIT = 8,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic req_in,
  input  logic gnt_in,
  output logic at_limit_out
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_in || gnt_in) begin
      cnt_d = '0;
    end else if (cnt_q != W'(LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_out = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates core LSU and DMA/debug requests onto one registered data-memory port.
// Define DMEM_TIMEOUT_EN to add err_out and a forced completion after TIMEOUT_CYCLES.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
`ifdef DMEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              core_req_in,
  input  logic              core_we_in,
  input  logic [ADDR_W-1:0] core_addr_in,
  input  logic [DATA_W-1:0] core_wdata_in,
  input  logic [MASK_W-1:0] core_mask_in,
  output logic              core_gnt_out,
  output logic [DATA_W-1:0] core_rdata_out,
  output logic              core_stall_out,
  input  logic              dma_req_in,
  input  logic              dma_we_in,
  input  logic [ADDR_W-1:0] dma_addr_in,
  input  logic [DATA_W-1:0] dma_wdata_in,
  input  logic [MASK_W-1:0] dma_mask_in,
  output logic              dma_gnt_out,
  output logic [DATA_W-1:0] dma_rdata_out,
  output logic              dm_req_out,
  output logic              dm_we_out,
  output logic [ADDR_W-1:0] dm_addr_out,
  output logic [DATA_W-1:0] dm_wdata_out,
  output logic [MASK_W-1:0] dm_mask_out,
  input  logic              dm_ack_in,
  input  logic [DATA_W-1:0] dm_rdata_in
`ifdef DMEM_TIMEOUT_EN
  , output logic            err_out
`endif
);

  arb_state_e state_q, state_d;
  dm_req_t    bus_q, bus_d;
  dm_req_t    core_bundle, dma_bundle;
  logic       dm_req_q, dm_req_d;
  owner_e     winner;
  logic       ack_done, force_done, done;
  logic       core_ok, dma_ok, starve_hit;

  assign core_bundle = '{we: core_we_in, addr: core_addr_in, wdata: core_wdata_in, mask: core_mask_in};
  assign dma_bundle  = '{we: dma_we_in, addr: dma_addr_in, wdata: dma_wdata_in, mask: dma_mask_in};

  assign ack_done = dm_ack_in && (state_q != IDLE);
  assign done     = ack_done || force_done;

`ifdef DMEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign force_done = (state_q != IDLE) && !dm_ack_in && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign tmo_d      = ((state_q == IDLE) || done) ? '0 : tmo_q + 1'b1;
  assign err_out    = force_done;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign force_done = 1'b0;
`endif

  // A forced (timed-out) completion never hands the bus over; only a real ack does.
  assign core_gnt_out   = (state_q == BUSY_CORE) && done;
  assign dma_gnt_out    = (state_q == BUSY_DMA) && done;
  assign core_rdata_out = (core_gnt_out && !force_done) ? dm_rdata_in : '0;
  assign dma_rdata_out  = (dma_gnt_out && !force_done) ? dm_rdata_in : '0;
  assign core_stall_out = core_req_in && !core_gnt_out;

  dmem_arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .req_in      (dma_req_in),
    .gnt_in      (dma_gnt_out),
    .at_limit_out(starve_hit)
  );

  // The retiring owner is excluded so the other side can follow back-to-back.
  assign core_ok = core_req_in && ((state_q == IDLE) || (ack_done && (state_q == BUSY_DMA)));
  assign dma_ok  = dma_req_in && ((state_q == IDLE) || (ack_done && (state_q == BUSY_CORE)));

  always_comb begin
    winner = OWN_NONE;
    if (dma_ok && starve_hit) begin
      winner = OWN_DMA;
    end else if (core_ok) begin
      winner = OWN_CORE;
    end else if (dma_ok) begin
      winner = OWN_DMA;
    end
  end

  always_comb begin
    state_d  = state_q;
    bus_d    = bus_q;
    dm_req_d = dm_req_q;
    if ((state_q == IDLE) || done) begin
      case (winner)
        OWN_CORE: begin
          state_d  = BUSY_CORE;
          bus_d    = core_bundle;
          dm_req_d = 1'b1;
        end
        OWN_DMA: begin
          state_d  = BUSY_DMA;
          bus_d    = dma_bundle;
          dm_req_d = 1'b1;
        end
        default: begin
          state_d  = IDLE;
          dm_req_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      bus_q    <= '0;
      dm_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus_q    <= bus_d;
      dm_req_q <= dm_req_d;
    end
  end

  assign dm_req_out   = dm_req_q;
  assign dm_we_out    = bus_q.we;
  assign dm_addr_out  = bus_q.addr;
  assign dm_wdata_out = bus_q.wdata;
  assign dm_mask_out  = bus_q.mask;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sits between data-memory requesters and the single data-memory port: the core LSU path (store-unit addr/data/mask outputs plus load requests) and a DMA/debug master.
- Grants one transaction at a time and holds a registered copy of the winning request on the memory bus until the memory acks.
- Returns the completion and read data to the owner, and gives the core a stall signal.
- Fixed core priority, with a starvation guard for DMA.

Parameters:
- STARVE_LIMIT, 8, consecutive DMA wait cycles after which DMA wins the next arbitration.
- TIMEOUT_CYCLES, 64, ack wait limit; used only with DMEM_TIMEOUT_EN.

Ports:
- clk_in  input  1  clock, all state on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- core_req_in  input  1  core request, held stable until core_gnt_out
- core_we_in  input  1  1=store, 0=load
- core_addr_in  input  32  byte address
- core_wdata_in  input  32  lane-aligned store data
- core_mask_in  input  4  byte write mask
- core_gnt_out  output  1  completion pulse to core
- core_rdata_out  output  32  load data, valid when core_gnt_out & ~core_we_in
- core_stall_out  output  1  core_req_in & ~core_gnt_out
- dma_req_in, dma_we_in, dma_addr_in[32], dma_wdata_in[32], dma_mask_in[4]  inputs  DMA request, same rules as core
- dma_gnt_out  output  1; dma_rdata_out  output  32  same rules as core
- dm_req_out  output  1  memory request, registered
- dm_we_out  output  1; dm_addr_out  output  32; dm_wdata_out  output  32; dm_mask_out  output  4  registered request fields
- dm_ack_in  input  1  memory completion, single cycle
- dm_rdata_in  input  32  read data, valid with dm_ack_in

Behaviour:
- Clock and reset: one clock (clk_in); rst_n_in is asynchronous, active-low.
- Reset values: state=IDLE; dm_req_out=0; dm_we_out=0; dm_addr_out, dm_wdata_out = 0; dm_mask_out=0; wait counter=0. All gnt outputs are 0.
- FSM states:
  - IDLE
  - BUSY_CORE
  - BUSY_DMA
- Arbitration, sampled on a clock edge:
  - If DMA is waiting and wait_cnt==STARVE_LIMIT, DMA wins.
  - Else, if core_req_in, core wins.
  - Else, if dma_req_in, DMA wins.
  - The winner's fields are latched into dm_* and dm_req_out=1 from the next cycle. State moves to BUSY_x.
- In BUSY_x, dm_* are held constant until dm_ack_in=1.
- Ack cycle:
  - x_gnt_out=1 combinationally in the same cycle.
  - x_rdata_out=dm_rdata_in passes through.
  - Non-owner gnt=0 and non-owner rdata=0.
- In the ack cycle, re-arbitration excludes the owner because its request is retiring. If the other requester is pending, go directly to its BUSY state (back-to-back, no idle bubble). Otherwise go to IDLE with dm_req_out=0.
- Latency: request at cycle N with the bus idle → dm_req_out at N+1 → gnt in the ack cycle, at minimum N+1.
- Wait counter:
  - Width $clog2(STARVE_LIMIT+1).
  - Increments each cycle dma_req_in=1 and dma_gnt_out=0, saturating at STARVE_LIMIT.
  - Clears on dma_gnt_out or when dma_req_in=0.
- Simultaneous core and DMA requests in IDLE with wait_cnt<STARVE_LIMIT: core wins.
- dm_ack_in while IDLE: ignored, with no gnt.
- Reset mid-transaction: the transaction is abandoned, dm_req_out drops asynchronously, and no gnt is issued.
- Requests dropped before gnt are a protocol violation; no recovery is required.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN
- With the macro:
  - Adds port err_out (output, 1 bit) and a timeout counter (reset 0).
  - The counter counts BUSY cycles without ack.
  - At TIMEOUT_CYCLES the block forces completion: owner gnt=1, rdata=32'h0, err_out=1 for that cycle, and dm_req_out drops.
  - A late ack is then ignored per the IDLE rule.
- Without the macro: no err_out port and no counter; BUSY waits indefinitely.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - the state enum (IDLE/BUSY_CORE/BUSY_DMA)
  - the owner-id encoding
  - default STARVE_LIMIT and TIMEOUT_CYCLES constants
  - the request-bundle field widths (ADDR_W=32, DATA_W=32, MASK_W=4)
- One natural sub-module, dmem_arb_starve_ctr: saturating wait counter with clear, parameterised by limit.

Test Plan:
- Single core store, addr=0x0000_1002, wdata=0x00AB_0000, mask=4'b0100, ack 2 cycles after dm_req_out → dm_* match the input from N+1 until ack; core_gnt_out=1 only in the ack cycle; core_stall_out=1 before it.
- DMA load, addr=0x0000_0040, with dm_rdata_in=0xCAFE_F00D at ack → dma_gnt_out=1 and dma_rdata_out=0xCAFE_F00D in the same cycle; core_gnt_out=0.
- Core and DMA both requesting in the same cycle with zero-wait acks → core served first, DMA dm_req_out in the cycle after the core ack with no IDLE bubble.
- Core requesting continuously with DMA held pending → DMA granted after wait_cnt reaches 8; the core then waits one transaction; the counter clears.
- Reset asserted during BUSY_DMA → dm_req_out=0 immediately with no clock needed; state=IDLE; no gnt.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → err_out=1 and core_gnt_out=1 with rdata=0 on the 4th BUSY cycle; a later stray ack is ignored.
